// File: rtl/config_chain_loader.sv
// Bit-serial loader for a chained config_cell column: shifts bitstream words into the chain head and packs the tail bits back into readback words.
// Latency: 2 clk per bit plus one FETCH cycle per word; done lands 2 clk after an accepted zero-length start.
// Backpressure: wr side is valid/ready (ready only in FETCH); rd side holds rd_valid until rd_ready, and shifting parks in SHI if a full rx word cannot be handed off.
//
// Ports:
//   clk, reset                   system clock, async active-high reset
//   start, clear_first, chain_bits   load request (sampled together, IDLE only)
//   wr_data/wr_valid/wr_ready    bitstream words in, bit 0 shifted first
//   rd_data/rd_valid/rd_ready    readback words out, first captured bit in bit 0
//   config_clk/config_reset/config_in   registered drive to chain head
//   config_out                   serial data from chain tail
//   busy, done                   status / one-cycle completion pulse
module config_chain_loader #(
  parameter int WORD  = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear_first,
  input  logic [LEN_W-1:0] chain_bits,
  input  logic [WORD-1:0]  wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WORD-1:0]  rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             config_clk,
  output logic             config_reset,
  output logic             config_in,
  input  logic             config_out,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WORD);

  typedef enum logic [2:0] {IDLE, CRST, FETCH, SLO, SHI, DRAIN, FIN} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] remain;
  logic             crst_cnt;
  logic [WORD-1:0]  tx;
  logic [WORD-1:0]  rx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   rx_idx;

  logic rd_free, rx_full, last_bit, pack, stall, wr_take;

  always_comb begin
    rd_free  = !rd_valid || rd_ready;
    rx_full  = (rx_idx == (IDX_W+1)'(WORD));
    last_bit = (remain == LEN_W'(1));
    // rx must be handed to rd_data either when full or on the final bit
    pack     = (state == SHI) && (rx_full || last_bit);
    // park with config_clk high rather than overwrite an unread rd word
    stall    = pack && !rd_free;
    wr_take  = wr_valid && wr_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (chain_bits == '0)  state_n = FIN;
          else if (clear_first)  state_n = CRST;
          else                   state_n = FETCH;
        end
      end
      CRST:  if (crst_cnt) state_n = FETCH;
      FETCH: if (wr_take) state_n = SLO;
      SLO:   state_n = SHI;
      SHI: begin
        if (!stall) begin
          if (last_bit)                       state_n = DRAIN;
          else if (idx == IDX_W'(WORD - 1))   state_n = FETCH;
          else                                state_n = SLO;
        end
      end
      DRAIN: if (rd_free) state_n = FIN;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remain       <= '0;
      crst_cnt     <= 1'b0;
      tx           <= '0;
      rx           <= '0;
      idx          <= '0;
      rx_idx       <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      wr_ready     <= 1'b0;
      config_clk   <= 1'b0;
      config_reset <= 1'b0;
      config_in    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Chain-facing strobes are decoded from the next state so they
      // line up exactly with the state they belong to, straight off a flop.
      wr_ready     <= (state_n == FETCH);
      config_clk   <= (state_n == SHI);
      config_reset <= (state_n == CRST);
      done         <= (state == FIN);

      if (rd_valid && rd_ready) rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          config_in <= 1'b0;
          if (start) begin
            remain   <= chain_bits;
            busy     <= 1'b1;
            rx       <= '0;
            rx_idx   <= '0;
            crst_cnt <= 1'b0;
          end
        end
        CRST: crst_cnt <= 1'b1;
        FETCH: begin
          if (wr_take) begin
            tx        <= wr_data;
            idx       <= '0;
            config_in <= wr_data[0];
          end
        end
        SLO: begin
          // tail value before the chain edge that follows this cycle
          rx[rx_idx[IDX_W-1:0]] <= config_out;
          rx_idx                <= rx_idx + (IDX_W+1)'(1);
        end
        SHI: begin
          if (!stall) begin
            remain <= remain - LEN_W'(1);
            if (pack) begin
              rd_data  <= rx;
              rd_valid <= 1'b1;
              rx       <= '0;
              rx_idx   <= '0;
            end
            if (last_bit) begin
              config_in <= 1'b0;
            end else if (idx != IDX_W'(WORD - 1)) begin
              idx       <= idx + IDX_W'(1);
              config_in <= tx[idx + IDX_W'(1)];
            end
          end
        end
        FIN: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a behavioural chain hanging off config_in/config_out.
// Each load runs cycle by cycle, feeding wr words, sinking rd words and timing done.
// Expected readback and chain contents are hand-computed constants.
module tb_config_chain_loader;
  localparam int WORD  = 32;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             clear_first;
  logic [LEN_W-1:0] chain_bits;
  logic [WORD-1:0]  wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [WORD-1:0]  rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             config_clk;
  logic             config_reset;
  logic             config_in;
  logic             config_out;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  config_chain_loader #(.WORD(WORD), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_first(clear_first),
    .chain_bits(chain_bits), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .config_clk(config_clk), .config_reset(config_reset),
    .config_in(config_in), .config_out(config_out), .busy(busy), .done(done)
  );

  // Behavioural chain: tail is bit 0, new bits enter at bit chain_len-1.
  logic [63:0] chain = '0;
  logic [63:0] chain_init = '0;
  int          chain_len = 5;
  int          set_req = 0;
  int          set_ack = 0;
  int          edges_total = 0;
  logic        cclk_prev = 1'b0;

  always @(negedge clk) begin
    if (set_req != set_ack) begin
      chain   = chain_init;
      set_ack = set_req;
    end
    if (config_reset) begin
      chain = '0;
    end else if (config_clk && !cclk_prev) begin
      chain = chain >> 1;
      chain[chain_len-1] = config_in;
      edges_total++;
    end
    cclk_prev = config_clk;
  end

  assign config_out = chain[0];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [WORD-1:0] wq [0:3];
  logic [WORD-1:0] rq [0:3];
  int widx, nr, dones, rstc, bad_order, edges;

  task automatic preset(input int len, input logic [63:0] v);
    chain_len  = len;
    chain_init = v;
    set_req++;
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Runs one load. hold_rd keeps rd_ready low until shifting has parked,
  // abort_at>0 asserts reset once that many chain edges have been seen.
  task automatic run_load(input int bits, input bit clr, input int nw,
                          input bit hold_rd, input logic [WORD-1:0] stall_exp,
                          input int abort_at);
    int cyc = 0;
    int post = 0;
    int stallc = 0;
    int base;
    bit released = 1'b0;
    base = edges_total;
    widx = 0; nr = 0; dones = 0; rstc = 0; bad_order = 0; edges = 0;
    start = 1'b1; chain_bits = LEN_W'(bits); clear_first = clr;
    @(negedge clk); #1;
    start = 1'b0;
    while (post < 3 && cyc < 600) begin
      edges = edges_total - base;
      if (done) dones++;
      if (config_reset) begin
        rstc++;
        if (edges > 0) bad_order++;
      end
      if (abort_at > 0 && edges == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_outputs_zero",
            64'({wr_ready, rd_valid, config_clk, config_reset, config_in, busy, done, rd_data}), 64'd0);
        @(negedge clk); #1;
        reset = 1'b0; wr_valid = 1'b0;
        return;
      end
      wr_valid = (widx < nw);
      wr_data  = wq[widx];
      if (wr_valid && wr_ready) widx++;
      if (hold_rd && !released && edges == bits) begin
        stallc++;
        if (stallc == 4) begin
          chk("stall_cclk_high", 64'(config_clk), 64'd1);
          chk("stall_rd_word0", 64'(rd_data), 64'(stall_exp));
          chk("stall_no_rd_taken", 64'(nr), 64'd0);
          released = 1'b1;
        end
      end
      rd_ready = !(hold_rd && !released);
      if (rd_valid && rd_ready) begin
        if (nr < 4) rq[nr] = rd_data;
        nr++;
      end
      if (dones > 0) post++;
      cyc++;
      @(negedge clk); #1;
    end
    edges = edges_total - base;
    chk("load_timeout", 64'(cyc < 600), 64'd1);
  endtask

  int base0;

  initial begin
    reset = 1'b1; start = 1'b0; clear_first = 1'b0; chain_bits = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs",
        64'({wr_ready, rd_valid, config_clk, config_reset, config_in, busy, done, rd_data}), 64'd0);
    reset = 1'b0;

    // 5-bit chain holding 01101, load 0x16
    preset(5, 64'h0D);
    wq[0] = 32'h0000_0016;
    run_load(5, 1'b0, 1, 1'b0, '0, 0);
    chk("t1_edges", 64'(edges), 64'd5);
    chk("t1_wr_words", 64'(widx), 64'd1);
    chk("t1_rd_words", 64'(nr), 64'd1);
    chk("t1_rd0", 64'(rq[0]), 64'h0000_000D);
    chk("t1_done", 64'(dones), 64'd1);
    chk("t1_no_creset", 64'(rstc), 64'd0);
    chk("t1_chain", chain, 64'h16);

    // 40 bits, readback held off so shifting parks after the last bit
    preset(40, 64'h12_3456_789A);
    wq[0] = 32'hA5A5_A5A5; wq[1] = 32'h0000_00FF; wq[2] = 32'hDEAD_BEEF;
    run_load(40, 1'b0, 3, 1'b1, 32'h3456_789A, 0);
    chk("t2_edges", 64'(edges), 64'd40);
    chk("t2_wr_words", 64'(widx), 64'd2);
    chk("t2_rd_words", 64'(nr), 64'd2);
    chk("t2_rd0", 64'(rq[0]), 64'h3456_789A);
    chk("t2_rd1", 64'(rq[1]), 64'h0000_0012);
    chk("t2_done", 64'(dones), 64'd1);
    chk("t2_chain", chain, 64'hFF_A5A5_A5A5);
    chk("t2_wr_ready_idle", 64'(wr_ready), 64'd0);
    wr_valid = 1'b0;

    // clear_first on a 4-bit chain holding 1111
    preset(4, 64'hF);
    wq[0] = 32'h0000_0009;
    run_load(4, 1'b1, 1, 1'b0, '0, 0);
    chk("t3_creset_cycles", 64'(rstc), 64'd2);
    chk("t3_creset_before_edge", 64'(bad_order), 64'd0);
    chk("t3_edges", 64'(edges), 64'd4);
    chk("t3_rd_words", 64'(nr), 64'd1);
    chk("t3_rd0", 64'(rq[0]), 64'd0);
    chk("t3_chain", chain, 64'h9);

    // zero-length load; a start during FIN must be ignored
    base0 = edges_total;
    start = 1'b1; chain_bits = '0; clear_first = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h1234_5678;
    @(negedge clk); #1;
    chk("t4_cycle1", 64'({busy, done, wr_ready}), 64'b100);
    @(negedge clk); #1;
    chk("t4_cycle2", 64'({busy, done, wr_ready}), 64'b010);
    start = 1'b0;
    @(negedge clk); #1;
    chk("t4_cycle3", 64'({busy, done, wr_ready}), 64'b000);
    chk("t4_edges", 64'(edges_total - base0), 64'd0);
    wr_valid = 1'b0;

    // reset after bit 17 of 40, then a clean full load
    preset(40, 64'h0);
    wq[0] = 32'hFFFF_FFFF; wq[1] = 32'h0000_00FF;
    run_load(40, 1'b0, 2, 1'b0, '0, 17);
    chk("t5_abort_edges", 64'(edges), 64'd17);
    @(negedge clk); #1;
    wq[0] = 32'h0; wq[1] = 32'h0;
    run_load(40, 1'b0, 2, 1'b0, '0, 0);
    chk("t5_edges", 64'(edges), 64'd40);
    chk("t5_wr_words", 64'(widx), 64'd2);
    chk("t5_rd_words", 64'(nr), 64'd2);
    chk("t5_rd0", 64'(rq[0]), 64'hFF80_0000);
    chk("t5_rd1", 64'(rq[1]), 64'h0000_00FF);
    chk("t5_done", 64'(dones), 64'd1);
    chk("t5_chain", chain, 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
